// File: rtl/wb_master_sequencer.sv
// rtl/wb_master_sequencer.sv - Single-beat Wishbone initiator with ACK timeout
module wb_master_sequencer #(
    parameter int                   ADDRWIDTH      = 17,
    parameter int                   DATAWIDTH      = 32,
    parameter int                   TIMEOUT_WIDTH  = 4,
    parameter int                   TIMEOUT_CYCLES = 15,
    parameter logic [DATAWIDTH-1:0] ERR_READ_VALUE = 32'hBADFABAC
) (
    input  logic                 WBm_CLK_i,
    input  logic                 WBm_RST_n_i,
    input  logic                 CMD_VALID_i,
    output logic                 CMD_READY_o,
    input  logic                 CMD_WE_i,
    input  logic [ADDRWIDTH-1:0] CMD_ADR_i,
    input  logic [3:0]           CMD_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] CMD_DAT_i,
    output logic                 RSP_VALID_o,
    input  logic                 RSP_READY_i,
    output logic [DATAWIDTH-1:0] RSP_DAT_o,
    output logic                 RSP_ERR_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic                 WBm_RD_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i,
    output logic                 Busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t r_state, w_state_nxt;

    logic                     r_cmd_ready,  w_cmd_ready_nxt;
    logic                     r_rsp_valid,  w_rsp_valid_nxt;
    logic [DATAWIDTH-1:0]     r_rsp_dat,    w_rsp_dat_nxt;
    logic                     r_rsp_err,    w_rsp_err_nxt;
    logic [ADDRWIDTH-1:0]     r_adr,        w_adr_nxt;
    logic                     r_cyc,        w_cyc_nxt;
    logic                     r_stb,        w_stb_nxt;
    logic                     r_we,         w_we_nxt;
    logic                     r_rd,         w_rd_nxt;
    logic [3:0]               r_byte_stb,   w_byte_stb_nxt;
    logic [DATAWIDTH-1:0]     r_dat,        w_dat_nxt;
    logic                     r_busy,       w_busy_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_cnt,        w_cnt_nxt;

    logic w_accept;
    logic w_timeout;

    // READY stays low for the first edge after reset so it comes up registered
    assign w_accept  = (r_state == S_IDLE) && r_cmd_ready && CMD_VALID_i;
    assign w_timeout = (r_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge WBm_CLK_i or negedge WBm_RST_n_i) begin
        if (!WBm_RST_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)                w_state_nxt = S_BUS;
            S_BUS:   if (WBm_ACK_i || w_timeout)  w_state_nxt = S_RESP;
            S_RESP:  if (RSP_READY_i)             w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;
        w_adr_nxt       = r_adr;
        w_cyc_nxt       = r_cyc;
        w_stb_nxt       = r_stb;
        w_we_nxt        = r_we;
        w_rd_nxt        = r_rd;
        w_byte_stb_nxt  = r_byte_stb;
        w_dat_nxt       = r_dat;
        w_busy_nxt      = r_busy;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_cyc_nxt       = 1'b1;
                    w_stb_nxt       = 1'b1;
                    w_we_nxt        = CMD_WE_i;
                    w_rd_nxt        = ~CMD_WE_i;
                    w_adr_nxt       = {CMD_ADR_i[ADDRWIDTH-1:2], 2'b00};
                    w_byte_stb_nxt  = CMD_BYTE_STB_i;
                    w_dat_nxt       = CMD_DAT_i;
                    w_busy_nxt      = 1'b1;
                    w_cnt_nxt       = '0;
                end
            end
            S_BUS: begin
                // ACK has priority over a timeout landing on the same edge
                if (WBm_ACK_i || w_timeout) begin
                    w_cyc_nxt       = 1'b0;
                    w_stb_nxt       = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_rd_nxt        = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = ~WBm_ACK_i;
                    if (r_we)
                        w_rsp_dat_nxt = '0;
                    else if (WBm_ACK_i)
                        w_rsp_dat_nxt = WBm_DAT_i;
                    else
                        w_rsp_dat_nxt = ERR_READ_VALUE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (RSP_READY_i) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                end
            end
            default: begin
                w_cmd_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge WBm_CLK_i or negedge WBm_RST_n_i) begin
        if (!WBm_RST_n_i) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_adr       <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rd        <= 1'b0;
            r_byte_stb  <= '0;
            r_dat       <= '0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_adr       <= w_adr_nxt;
            r_cyc       <= w_cyc_nxt;
            r_stb       <= w_stb_nxt;
            r_we        <= w_we_nxt;
            r_rd        <= w_rd_nxt;
            r_byte_stb  <= w_byte_stb_nxt;
            r_dat       <= w_dat_nxt;
            r_busy      <= w_busy_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign CMD_READY_o    = r_cmd_ready;
    assign RSP_VALID_o    = r_rsp_valid;
    assign RSP_DAT_o      = r_rsp_dat;
    assign RSP_ERR_o      = r_rsp_err;
    assign WBm_ADR_o      = r_adr;
    assign WBm_CYC_o      = r_cyc;
    assign WBm_STB_o      = r_stb;
    assign WBm_WE_o       = r_we;
    assign WBm_RD_o       = r_rd;
    assign WBm_BYTE_STB_o = r_byte_stb;
    assign WBm_DAT_o      = r_dat;
    assign Busy_o         = r_busy;

endmodule
